// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// No logic; states and stream framing sizes only.
// No flow control here; see imem_boot_loader.
package imem_loader_pkg;

    // Loader control states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    // Length prefix is a 16-bit little-endian word count
    localparam int LEN_BYTES      = 2;
    // Bytes per instruction word, least-significant byte first
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Packs bytes LSB-first into a word; lane counter wraps after the last lane.
// Latency: word complete in the cycle after the final push; word_ready is combinational.
// Backpressure: none; the caller only pushes bytes it has accepted.
module byte_word_packer
    import imem_loader_pkg::*;
#(
    parameter int LANES = BYTES_PER_WORD
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic [7:0]           data,
    output logic [8*LANES-1:0]   word,
    output logic                 word_ready
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [LW-1:0]        r_lane;
    logic [8*LANES-1:0]   r_word;

    // Steer each pushed byte into the next lane; clear restarts at lane 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (push) begin
            r_word[8*r_lane +: 8] <= data;
            r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + LW'(1);
        end
    end

    assign word       = r_word;
    assign word_ready = push && (r_lane == LAST_LANE);

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory from address 0, holding the core meanwhile.
// Latency: write strobe the cycle after a word's 4th byte is accepted; 5 cycles minimum per word.
// Backpressure: rx_ready high only in LEN/DATA, dropped for the one-cycle WRITE and outside a load.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 12,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_writeEnable,
    output logic [ADDR_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    input  logic                  cpu_readEnable,
    output logic                  mem_readEnable,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Word counter has one extra bit so a full-depth image can terminate
    localparam int          CW        = ADDR_WIDTH + 1;
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam int          TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    loader_state_t   r_state;
    loader_state_t   w_next;
    logic [7:0]      r_len_lo;
    logic            r_len_idx;
    logic [15:0]     r_n;
    logic [CW-1:0]   r_word_cnt;
    logic [TW-1:0]   r_idle;

    logic            w_rx_ready;
    logic            w_accept;
    logic            w_len_done;
    logic [15:0]     w_len_n;
    logic            w_len_bad;
    logic            w_last_word;
    logic            w_timeout;
    logic            w_word_ready;
    logic [8*BYTES_PER_WORD-1:0] w_word;

    assign w_rx_ready  = (r_state == ST_LEN) || (r_state == ST_DATA);
    assign w_accept    = rx_valid && w_rx_ready;
    assign w_len_done  = w_accept && (r_state == ST_LEN) && r_len_idx;
    assign w_len_n     = {rx_data, r_len_lo};
    assign w_len_bad   = (w_len_n == 16'd0) || (32'(w_len_n) > MAX_WORDS);
    assign w_last_word = (32'(r_word_cnt) + 32'd1) == 32'(r_n);
    // An accepted byte on the same edge always beats the timeout
    assign w_timeout   = TO_EN && (r_idle == TO_LAST) && !w_accept;

    byte_word_packer #(
        .LANES (BYTES_PER_WORD)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (r_state == ST_LEN),
        .push       (w_accept && (r_state == ST_DATA)),
        .data       (rx_data),
        .word       (w_word),
        .word_ready (w_word_ready)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived status outputs
    always_comb begin
        w_next          = r_state;
        mem_writeEnable = 1'b0;
        core_hold       = 1'b1;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LEN;
            end
            ST_LEN: begin
                busy = 1'b1;
                if (w_len_done)     w_next = w_len_bad ? ST_ERROR : ST_DATA;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_DATA: begin
                busy = 1'b1;
                if (w_accept && w_word_ready) w_next = ST_WRITE;
                else if (w_timeout)           w_next = ST_ERROR;
            end
            ST_WRITE: begin
                busy            = 1'b1;
                mem_writeEnable = 1'b1;
                w_next          = w_last_word ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
                if (start) w_next = ST_LEN;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) w_next = ST_LEN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Length prefix capture and word address counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len_lo   <= '0;
            r_len_idx  <= 1'b0;
            r_n        <= '0;
            r_word_cnt <= '0;
        end else begin
            if (r_state != ST_LEN) begin
                r_len_idx <= 1'b0;
            end else if (w_accept) begin
                r_len_idx <= 1'b1;
                if (!r_len_idx) r_len_lo <= rx_data;
            end
            if (w_len_done) begin
                r_n        <= w_len_n;
                r_word_cnt <= '0;
            end else if (r_state == ST_WRITE) begin
                r_word_cnt <= r_word_cnt + CW'(1);
            end
        end
    end

    // Idle counter: runs only while waiting for bytes, cleared by any accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if (!TO_EN || !w_rx_ready || w_accept) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + TW'(1);
        end
    end

    assign rx_ready         = w_rx_ready;
    assign mem_writeAddress = r_word_cnt[ADDR_WIDTH-1:0];
    assign mem_writeData    = w_word;
    assign mem_readEnable   = cpu_readEnable & ~core_hold;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
// Stimulus drives bytes #1 after the rising edge; outputs are sampled on the falling edge.
// Expected writes are queued as words are sent and popped by the write monitor.
module tb_imem_boot_loader;

    localparam int AW = 12;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          cpu_readEnable = 1'b0;
    logic          rx_ready;
    logic          mem_writeEnable;
    logic [AW-1:0] mem_writeAddress;
    logic [31:0]   mem_writeData;
    logic          mem_readEnable;
    logic          core_hold;
    logic          busy;
    logic          done;
    logic          error;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            n_writes = 0;
    int            exp_addr = 0;
    int            w0;
    int            k;
    logic [AW-1:0] last_addr = '0;

    imem_boot_loader #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .mem_writeEnable  (mem_writeEnable),
        .mem_writeAddress (mem_writeAddress),
        .mem_writeData    (mem_writeData),
        .cpu_readEnable   (cpu_readEnable),
        .mem_readEnable   (mem_readEnable),
        .core_hold        (core_hold),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clock = ~clock;

    // Write monitor: every strobe must match the next queued word
    always @(negedge clock) begin
        if (mem_writeEnable === 1'b1) begin
            n_writes  = n_writes + 1;
            last_addr = mem_writeAddress;
            n_assert++;
            assert (rx_ready === 1'b0 && mem_readEnable === 1'b0)
            else begin
                n_fail++;
                $error("FAIL write_cycle_gating rx_ready=%b mem_readEnable=%b expected 0/0", rx_ready, mem_readEnable);
            end
            n_assert++;
            assert (exp_q.size() != 0)
            else begin
                n_fail++;
                $error("FAIL unexpected_write addr=%0d data=%h expected no write", mem_writeAddress, mem_writeData);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                n_assert++;
                assert ({mem_writeAddress, mem_writeData} === mon_e)
                else begin
                    n_fail++;
                    $error("FAIL write_data addr=%0d data=%h expected addr=%0d data=%h",
                           mem_writeAddress, mem_writeData, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, assertions=%0d failures=%0d", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        logic r;
        acc = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            r = rx_ready;
            @(posedge clock); #1;
            if (r) acc = 1'b1;
        end
        rx_valid = 1'b0;
        check("byte_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_len(input logic [15:0] n);
        exp_addr = 0;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        int g;
        exp_q.push_back({exp_addr[AW-1:0], w});
        exp_addr++;
        for (int i = 0; i < 4; i++) begin
            g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            repeat (g) begin
                @(posedge clock); #1;
            end
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && done !== 1'b1; i++) begin
            @(posedge clock); #1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        // Reset values
        cpu_readEnable = 1'b1;
        #12;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we", {31'd0, mem_writeEnable}, 32'd0);
        check("rst_addr", {20'd0, mem_writeAddress}, 32'd0);
        check("rst_data", mem_writeData, 32'd0);
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_mem_re", {31'd0, mem_readEnable}, 32'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        // Basic three-word image
        do_start();
        check("len_busy", {31'd0, busy}, 32'd1);
        check("len_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_len(16'd3);
        send_word(32'h0000_0013, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'h1234_5678, 0);
        @(negedge clock);
        check("final_we", {31'd0, mem_writeEnable}, 32'd1);
        check("final_addr", {20'd0, mem_writeAddress}, 32'd2);
        check("pre_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        check("done_after_write", {31'd0, done}, 32'd1);
        check("hold_released", {31'd0, core_hold}, 32'd0);
        check("done_not_busy", {31'd0, busy}, 32'd0);
        check("done_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("done_mem_re", {31'd0, mem_readEnable}, 32'd1);
        check("basic_writes", n_writes, 32'd3);
        @(posedge clock); #1;

        // Zero-length image is rejected, then a good load recovers
        do_start();
        check("restart_hold", {31'd0, core_hold}, 32'd1);
        w0 = n_writes;
        send_len(16'd0);
        @(negedge clock);
        check("n0_error", {31'd0, error}, 32'd1);
        check("n0_hold", {31'd0, core_hold}, 32'd1);
        check("n0_done", {31'd0, done}, 32'd0);
        check("n0_no_write", n_writes - w0, 32'd0);
        @(posedge clock); #1;
        do_start();
        check("err_cleared", {31'd0, error}, 32'd0);
        send_len(16'd1);
        send_word(32'hCAFE_F00D, 1);
        wait_done("n1_done");
        check("n1_error", {31'd0, error}, 32'd0);

        // Oversized image rejected; full-depth image accepted
        do_start();
        send_len(16'd4097);
        @(negedge clock);
        check("n4097_error", {31'd0, error}, 32'd1);
        @(posedge clock); #1;
        do_start();
        w0 = n_writes;
        send_len(16'd4096);
        for (int i = 0; i < 4096; i++) send_word((i * 32'h9E37_79B9) ^ 32'hA5A5_0000, 0);
        wait_done("full_done");
        check("full_writes", n_writes - w0, 32'd4096);
        check("full_last_addr", {20'd0, last_addr}, 32'd4095);

        // Stream stall mid-load times out after TO idle cycles
        do_start();
        w0 = n_writes;
        send_len(16'd2);
        send_word(32'h0BAD_F00D, 0);
        send_byte(8'h11);
        k = 0;
        while (k < 40 && error !== 1'b1) begin
            @(posedge clock); #1;
            k++;
        end
        check("timeout_cycles", k, TO);
        check("timeout_error", {31'd0, error}, 32'd1);
        check("timeout_writes", n_writes - w0, 32'd1);

        // Random rx_valid gaps; a mid-load start must be ignored
        do_start();
        w0 = n_writes;
        send_len(16'd3);
        send_word($urandom, 3);
        do_start();
        check("start_ignored_busy", {31'd0, busy}, 32'd1);
        send_word($urandom, 3);
        send_word($urandom, 3);
        wait_done("rand_done");
        check("rand_writes", n_writes - w0, 32'd3);

        // Asynchronous reset in the middle of word 2
        do_start();
        send_len(16'd3);
        send_word(32'h0102_0304, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 reset = 1'b1;
        #1;
        check("areset_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_hold", {31'd0, core_hold}, 32'd1);
        check("areset_addr", {20'd0, mem_writeAddress}, 32'd0);
        check("areset_data", mem_writeData, 32'd0);
        check("areset_mem_re", {31'd0, mem_readEnable}, 32'd0);
        @(negedge clock); reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_mem_re", {31'd0, mem_readEnable}, 32'd0);
        do_start();
        send_len(16'd1);
        send_word(32'h5555_AAAA, 2);
        check("load_mem_re", {31'd0, mem_readEnable}, 32'd0);
        wait_done("post_reset_done");
        check("post_done_mem_re", {31'd0, mem_readEnable}, 32'd1);
        cpu_readEnable = 1'b0;
        #1;
        check("cpu_re_off", {31'd0, mem_readEnable}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the core's instruction memory: it owns the instruction memory's write port and gates its fetch read port. It accepts a length-prefixed byte stream, typically from the UART receiver, and packs it into little-endian 32-bit words. It writes those words sequentially from address 0, holding the core in stall until the image is complete. It releases the core on success and latches an error on a malformed or stalled stream.

## Interface
- `ADDR_WIDTH`, 12: instruction memory word-address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 32: memory word width; fixed at 4 bytes.
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles allowed between accepted bytes mid-load; 0 disables the timeout.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin or restart a load; sampled in IDLE, DONE and ERROR only.
- `rx_valid` in 1: byte-stream valid.
- `rx_data` in 8: byte-stream data.
- `rx_ready` out 1: loader can accept a byte.
- `mem_writeEnable` out 1: instruction memory write strobe.
- `mem_writeAddress` out ADDR_WIDTH: instruction memory write address.
- `mem_writeData` out DATA_WIDTH: instruction memory write word.
- `cpu_readEnable` in 1: core fetch enable.
- `mem_readEnable` out 1: equals `cpu_readEnable & ~core_hold`, combinational.
- `core_hold` out 1: stall/hold request to the core.
- `busy` out 1: high in LEN, DATA and WRITE.
- `done` out 1: high in DONE.
- `error` out 1: high in ERROR.

## Operation
- States: IDLE, LEN, DATA, WRITE, DONE, ERROR. `reset` forces IDLE.
- Stream format: 2-byte word count N, little-endian. N words follow, each 4 bytes, least-significant byte first.
- IDLE: `start` goes to LEN.
- LEN: accepts 2 bytes. After the 2nd byte, N==0 or N>2**ADDR_WIDTH goes to ERROR; otherwise go to DATA and clear the address and word counters.
- DATA: accepts bytes into byte lanes 0..3 in order. The 4th byte goes to WRITE.
- WRITE: one cycle. Drive `mem_writeEnable`=1, `mem_writeAddress`=word counter, `mem_writeData`=assembled word. Then increment the counter. If counter+1==N go to DONE, else go to DATA.
- DONE: `core_hold`=0 and `done`=1. `start` goes to LEN and reasserts `core_hold`.
- ERROR: `core_hold`=1 and `error`=1. `start` goes to LEN and clears `error`.
- Timeout: an idle counter runs in LEN and DATA and clears on every accepted byte. If it reaches TIMEOUT_CYCLES, go to ERROR.
- `start` in LEN, DATA or WRITE is ignored.
- Word counter is ADDR_WIDTH+1 bits so that N=2**ADDR_WIDTH terminates correctly. The address output uses the low ADDR_WIDTH bits.

## Timing
- Reset values: `rx_ready`=0, `mem_writeEnable`=0, `mem_writeAddress`=0, `mem_writeData`=0, `core_hold`=1, `busy`=0, `done`=0, `error`=0. All internal counters are 0.
- `rx_ready` is high in LEN and DATA and low in all other states, including the WRITE cycle.
- A byte is accepted on a rising edge with `rx_valid & rx_ready`. `rx_data` must be stable while `rx_valid` is high.
- Write latency: `mem_writeEnable` pulses for exactly 1 cycle, in the cycle after the edge that accepts a word's 4th byte.
- `rx_ready` returns high the cycle after WRITE, unless the load is complete.
- Minimum cost per word: 5 cycles.
- `done` and the `core_hold` deassertion occur in the cycle after the final WRITE.
- `mem_readEnable` is combinational. It is 0 throughout a load, so there is no simultaneous read and write.
- Reset mid-load: asynchronous abort to IDLE. `core_hold` stays 1, and partially written memory contents are left as-is.
- Timeout and byte accept on the same edge: the accept wins and the idle counter clears.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `LEN_BYTES`=2;
  - `BYTES_PER_WORD`=4.
- One sub-module is natural: `byte_word_packer`, a lane counter plus a 32-bit shift/assemble register with `clear`, `push` and `word_ready`.
- FSM, counters and timeout stay in the top module.

## Test plan
- Send N=3 (bytes 03 00), then words 0x00000013, 0xDEADBEEF, 0x12345678 as LSB-first bytes. Required: writes to addresses 0, 1, 2 with exactly those data. `done`=1 and `core_hold`=0 one cycle after the 3rd write.
- Send N=0 (bytes 00 00). Required: ERROR, `error`=1, `core_hold`=1, and no `mem_writeEnable` pulse. Then `start` plus N=1 and one word: load succeeds and `error` clears.
- Send N=4097 (bytes 01 10) with ADDR_WIDTH=12. Required: ERROR. Send N=4096: 4096 writes, the last one to address 4095, then DONE.
- Set TIMEOUT_CYCLES=16, send N=2 and 5 data bytes, then hold `rx_valid` low. Required: ERROR 16 cycles after the last accept, with only 1 write.
- Toggle `rx_valid` randomly during a load. Required: `rx_ready` is low in every WRITE cycle, and the word sequence is unchanged.
- Assert `reset` asynchronously midway through word 2. Required: outputs at reset values immediately, without waiting for a clock edge. `cpu_readEnable`=1 yields `mem_readEnable`=0 until a later load reaches DONE.
